// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: Moore state register with registered per-state controls.
// Define MC_ADDI_EN to build in the addi path (ADDIEX/ADDIWB); otherwise opcode 001000 is illegal.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
`ifdef MC_ADDI_EN
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`endif
        S_JEX    = 4'd11
    } state_e;

    // Pure per-state controls; the in_* flags mark states whose outputs are
    // further qualified by mem_ready, zero or opcode in the same cycle.
    typedef struct packed {
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       in_fetch;
        logic       in_decode;
        logic       in_memwr;
        logic       in_beq;
        logic       in_jex;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   op_legal;

    function automatic ctrl_t decode_state(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb  = 2'b01;
                c.in_fetch = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb   = 2'b11;
                c.in_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.in_memwr = 1'b1;
            end
            S_RTEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_RTWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.in_beq  = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB: c.regwrite = 1'b1;
`endif
            S_JEX: begin
                c.pcsrc  = 2'b10;
                c.in_jex = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MC_ADDI_EN
            OP_ADDI: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQEX;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEX:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BEQEX:  state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            S_JEX:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Controls are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_state(state_d);
        end
    end

    // rst masks every output so nothing leaks while the register sits in FETCH.
    always_comb begin
        state      = state_q;
        iord       = ~rst & ctrl_q.iord;
        regdst     = ~rst & ctrl_q.regdst;
        memtoreg   = ~rst & ctrl_q.memtoreg;
        regwrite   = ~rst & ctrl_q.regwrite;
        alusrca    = ~rst & ctrl_q.alusrca;
        alusrcb    = rst ? 2'b00 : ctrl_q.alusrcb;
        aluop      = rst ? 2'b00 : ctrl_q.aluop;
        pcsrc      = rst ? 2'b00 : ctrl_q.pcsrc;
        irwrite    = ~rst & ctrl_q.in_fetch & mem_ready;
        memwrite   = ~rst & ctrl_q.in_memwr & mem_ready;
        pc_en      = ~rst & ((ctrl_q.in_fetch & mem_ready) |
                             (ctrl_q.in_beq & zero) |
                             ctrl_q.in_jex);
        illegal_op = ~rst & ctrl_q.in_decode & ~op_legal;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction step lists expand into expected per-cycle traces.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;
    logic       illegal_op;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .state(state),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

    typedef struct { logic [3:0] st; logic mr; } step_t;
    step_t trace[$];

    int n_cmp = 0, n_fail = 0;
    int n_regwrite, n_memwrite, n_pcen_out, n_illegal, n_hold;

    logic [18:0] dut_vec;
    assign dut_vec = {state, pc_en, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                      alusrca, alusrcb, aluop, pcsrc, illegal_op};

    function automatic logic legal(input logic [5:0] op);
        legal = (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == J);
`ifdef MC_ADDI_EN
        if (op == ADDI) legal = 1'b1;
`endif
    endfunction

    // Output table by state number, straight from the per-state output lists.
    function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic mr,
                                            input logic z, input logic ill);
        logic pe, io, mw, irw, rd, mtr, rw, sa, il;
        logic [1:0] sb, op, ps;
        {pe, io, mw, irw, rd, mtr, rw, sa, il} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin pe = mr; irw = mr; sb = 2'b01; end
            4'd1:  begin sb = 2'b11; il = ill; end
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  io = 1'b1;
            4'd4:  begin mtr = 1'b1; rw = 1'b1; end
            4'd5:  begin io = 1'b1; mw = mr; end
            4'd6:  begin sa = 1'b1; op = 2'b10; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'b01; ps = 2'b01; pe = z; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {st, pe, io, mw, irw, rd, mtr, rw, sa, sb, op, ps, il};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        trace.push_back(s);
    endtask

    // Instruction-level model: each step repeats once per mem_ready=0 cycle where it waits.
    task automatic build(input logic [5:0] op, input int fw, input int mw, input logic dc);
        trace.delete();
        repeat (fw) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, dc);
        if (op == LW) begin
            push(4'd2, dc);
            repeat (mw) push(4'd3, 1'b0);
            push(4'd3, 1'b1);
            push(4'd4, dc);
        end else if (op == SW) begin
            push(4'd2, dc);
            repeat (mw) push(4'd5, 1'b0);
            push(4'd5, 1'b1);
        end else if (op == RT) begin
            push(4'd6, dc); push(4'd7, dc);
        end else if (op == BEQ) begin
            push(4'd8, dc);
        end else if (op == J) begin
            push(4'd11, dc);
        end else if (op == ADDI && legal(op)) begin
            push(4'd9, dc); push(4'd10, dc);
        end
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic z, input int fw,
                       input int mw, input logic dc, input int exp_len, input int stop_at);
        build(op, fw, mw, dc);
        check({name, " cycles"}, trace.size(), exp_len);
        n_regwrite = 0; n_memwrite = 0; n_pcen_out = 0; n_illegal = 0; n_hold = 0;
        for (int i = 0; i < int'(trace.size()) && i <= stop_at; i++) begin
            @(negedge clk);
            opcode = op;
            zero = z;
            mem_ready = trace[i].mr;
            #1;
            check($sformatf("%s cyc%0d", name, i), dut_vec,
                  exp_vec(trace[i].st, trace[i].mr, z, (trace[i].st == 4'd1) && !legal(op)));
            check($sformatf("%s wr_excl%0d", name, i), memwrite & regwrite, 0);
            n_regwrite += int'(regwrite);
            n_memwrite += int'(memwrite);
            n_illegal  += int'(illegal_op);
            if (pc_en && state != 4'd0) n_pcen_out++;
            if (state == 4'd5 && !memwrite) n_hold++;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h3f; zero = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset outputs", dut_vec, 0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1 check("reset release", dut_vec, exp_vec(4'd0, 1'b0, zero, 1'b0));

        run("lw", LW, 1'b1, 0, 0, 1'b1, 5, 1000);
        check("lw regwrite cycles", n_regwrite, 1);
        run("sw", SW, 1'b1, 0, 2, 1'b0, 6, 1000);
        check("sw memwrite cycles", n_memwrite, 1);
        check("sw hold cycles", n_hold, 2);
        run("beq_z1", BEQ, 1'b1, 0, 0, 1'b0, 3, 1000);
        check("beq_z1 pc_en", n_pcen_out, 1);
        run("beq_z0", BEQ, 1'b0, 0, 0, 1'b1, 3, 1000);
        check("beq_z0 pc_en", n_pcen_out, 0);
        run("j", J, 1'b0, 0, 0, 1'b0, 3, 1000);
        check("j pc_en", n_pcen_out, 1);
        run("ill3f", 6'b111111, 1'b0, 0, 0, 1'b1, 2, 1000);
        check("ill3f illegal cycles", n_illegal, 1);
`ifdef MC_ADDI_EN
        run("addi", ADDI, 1'b1, 0, 0, 1'b1, 4, 1000);
        check("addi regwrite cycles", n_regwrite, 1);
`else
        run("addi_ill", ADDI, 1'b1, 0, 0, 1'b1, 2, 1000);
        check("addi_ill illegal cycles", n_illegal, 1);
`endif
        run("rt_fw2", RT, 1'b1, 2, 0, 1'b0, 6, 1000);
        check("rt regwrite cycles", n_regwrite, 1);
        run("lw_waits", LW, 1'b0, 1, 2, 1'b0, 8, 1000);
        run("ill01", 6'b000001, 1'b1, 0, 0, 1'b0, 2, 1000);
        check("ill01 illegal cycles", n_illegal, 1);

        // Abort a load while MEMRD is stalled, between clock edges.
        run("lw_abort", LW, 1'b1, 0, 3, 1'b1, 8, 3);
        #2 rst = 1'b1; mem_ready = 1'b1;
        #1 check("rst async mid MEMRD", dut_vec, 0);
        @(posedge clk);
        #1 check("rst held", dut_vec, 0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1 check("rst release mid", dut_vec, exp_vec(4'd0, 1'b0, zero, 1'b0));
        run("rt_after_rst", RT, 1'b0, 0, 0, 1'b1, 4, 1000);

        @(negedge clk);
        mem_ready = 1'b0;
        #1 check("final state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
